// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM with memory handshake, halt/trap and retire counter
module mc_controller #(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                sign,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                signed_ext,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                lhu,
    output logic                jal,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    // Instruction class: everything after DECODE only needs to know which path to take
    typedef enum logic [3:0] {
        K_ALU, K_LOAD, K_STORE, K_BEQ, K_BNE, K_BGEZ,
        K_J, K_JAL, K_JR, K_SYSCALL, K_ILLEGAL
    } kind_t;

    state_t           r_state;
    kind_t            r_kind;
    logic [3:0]       r_alu_op;
    logic             r_alu_src;
    logic             r_signed_ext;
    logic             r_reg_dst;
    logic             r_mem_to_reg;
    logic             r_lhu;
    logic             r_jal;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    kind_t            w_kind;
    logic [3:0]       w_alu_op;
    logic             w_alu_src;
    logic             w_signed_ext;
    logic             w_reg_dst;
    logic             w_mem_to_reg;
    logic             w_lhu;
    logic             w_jal;

    // Combinational decode of op/func; only consumed while in DECODE
    always_comb begin
        w_kind       = K_ILLEGAL;
        w_alu_op     = 4'd0;
        w_alu_src    = 1'b0;
        w_signed_ext = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_lhu        = 1'b0;
        w_jal        = 1'b0;
        case (op)
            6'd0: begin
                w_kind = K_ALU;
                case (func)
                    6'd0:         w_alu_op = 4'd0;
                    6'd2:         w_alu_op = 4'd2;
                    6'd3:         w_alu_op = 4'd1;
                    6'd32, 6'd33: w_alu_op = 4'd5;
                    6'd34:        w_alu_op = 4'd6;
                    6'd36:        w_alu_op = 4'd7;
                    6'd37:        w_alu_op = 4'd8;
                    6'd38:        w_alu_op = 4'd9;
                    6'd39:        w_alu_op = 4'd10;
                    6'd42:        w_alu_op = 4'd11;
                    6'd43:        w_alu_op = 4'd12;
                    6'd8: begin
                        w_kind   = K_JR;
                        w_alu_op = 4'd5;
                    end
                    6'd12:        w_kind = K_SYSCALL;
                    default:      w_kind = K_ILLEGAL;
                endcase
                // Only real R-type ALU ops write rd
                w_reg_dst = (w_kind == K_ALU);
            end
            6'd1: begin
                w_kind = K_BGEZ; w_alu_op = 4'd11; w_signed_ext = 1'b1;
            end
            6'd2: w_kind = K_J;
            6'd3: begin
                w_kind = K_JAL; w_jal = 1'b1;
            end
            6'd4: begin
                w_kind = K_BEQ; w_alu_op = 4'd6; w_signed_ext = 1'b1;
            end
            6'd5: begin
                w_kind = K_BNE; w_alu_op = 4'd6; w_signed_ext = 1'b1;
            end
            6'd8, 6'd9: begin
                w_kind = K_ALU; w_alu_op = 4'd5; w_alu_src = 1'b1; w_signed_ext = 1'b1;
            end
            6'd10: begin
                w_kind = K_ALU; w_alu_op = 4'd11; w_alu_src = 1'b1; w_signed_ext = 1'b1;
            end
            6'd12: begin
                w_kind = K_ALU; w_alu_op = 4'd7; w_alu_src = 1'b1;
            end
            6'd13: begin
                w_kind = K_ALU; w_alu_op = 4'd8; w_alu_src = 1'b1;
            end
            6'd14: begin
                w_kind = K_ALU; w_alu_op = 4'd9; w_alu_src = 1'b1;
            end
            6'd35, 6'd37: begin
                w_kind = K_LOAD; w_alu_op = 4'd5; w_alu_src = 1'b1; w_signed_ext = 1'b1;
                w_mem_to_reg = 1'b1; w_lhu = (op == 6'd37);
            end
            6'd43: begin
                w_kind = K_STORE; w_alu_op = 4'd5; w_alu_src = 1'b1; w_signed_ext = 1'b1;
            end
            default: w_kind = K_ILLEGAL;
        endcase
    end

    // Sequencer: state transitions, decode-field latching, sticky trap and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_kind       <= K_ALU;
            r_alu_op     <= 4'd0;
            r_alu_src    <= 1'b0;
            r_signed_ext <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_lhu        <= 1'b0;
            r_jal        <= 1'b0;
            r_illegal    <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_kind       <= w_kind;
                    r_alu_op     <= w_alu_op;
                    r_alu_src    <= w_alu_src;
                    r_signed_ext <= w_signed_ext;
                    r_reg_dst    <= w_reg_dst;
                    r_mem_to_reg <= w_mem_to_reg;
                    r_lhu        <= w_lhu;
                    r_jal        <= w_jal;
                    case (w_kind)
                        K_SYSCALL: begin
                            r_state <= S_HALT;
                            r_count <= r_count + CNT_W'(1);
                        end
                        K_ILLEGAL: begin
                            r_illegal <= 1'b1;
                            r_state   <= S_HALT;
                        end
                        K_J, K_JAL: begin
                            r_state <= S_FETCH;
                            r_count <= r_count + CNT_W'(1);
                        end
                        default: r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (r_kind)
                        K_BEQ, K_BNE, K_BGEZ, K_JR: begin
                            r_state <= S_FETCH;
                            r_count <= r_count + CNT_W'(1);
                        end
                        K_LOAD, K_STORE: r_state <= S_MEM;
                        default:         r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (r_kind == K_STORE) begin
                            r_state <= S_FETCH;
                            r_count <= r_count + CNT_W'(1);
                        end else begin
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + CNT_W'(1);
                end
                S_HALT: begin
                    // A trap can only be left through reset
                    if (!r_illegal && resume) r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Datapath strobes, decoded from the current state so they drop with an async reset
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_kind == K_J || w_kind == K_JAL) begin
                    pc_write  = 1'b1;
                    pc_src    = 2'd2;
                    reg_write = (w_kind == K_JAL);
                end
            end
            S_EXEC: begin
                case (r_kind)
                    K_BEQ: begin
                        pc_write = zero;
                        pc_src   = 2'd1;
                    end
                    K_BNE: begin
                        pc_write = !zero;
                        pc_src   = 2'd1;
                    end
                    K_BGEZ: begin
                        pc_write = !sign;
                        pc_src   = 2'd1;
                    end
                    K_JR: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (r_kind == K_LOAD);
                mem_write = (r_kind == K_STORE);
            end
            S_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign alu_op      = ALU_OP_W'(r_alu_op);
    assign alu_src     = r_alu_src;
    assign signed_ext  = r_signed_ext;
    assign reg_dst     = r_reg_dst;
    assign mem_to_reg  = r_mem_to_reg;
    assign lhu         = r_lhu;
    // JAL writes $31 during DECODE, before its decode fields have been latched
    assign jal         = (r_state == S_DECODE) ? w_jal : r_jal;
    assign halted      = (r_state == S_HALT);
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller against an instruction-level model
`timescale 1ns/1ps
module tb_mc_controller;

    localparam int CW = 4;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_BGEZ = 6;
    localparam int K_J = 7, K_JAL = 8, K_JR = 9, K_SYS = 10, K_ILL = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    op = '0;
    logic [5:0]    func = '0;
    logic          zero = 1'b0;
    logic          sign = 1'b0;
    logic          mem_ready = 1'b0;
    logic          resume = 1'b0;
    logic          mem_read, mem_write, iord, ir_write, pc_write, reg_write;
    logic [1:0]    pc_src;
    logic [3:0]    alu_op;
    logic          alu_src, signed_ext, reg_dst, mem_to_reg, lhu, jal, halted, illegal;
    logic [CW-1:0] instr_count;

    mc_controller #(.ALU_OP_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .sign(sign),
        .mem_ready(mem_ready), .resume(resume),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .alu_op(alu_op),
        .alu_src(alu_src), .signed_ext(signed_ext), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .lhu(lhu), .jal(jal), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic       pw;
        logic [1:0] ps;
        logic       irw;
        logic       rw;
        logic       jl;
        logic       mr;
        logic       mw;
        logic       io;
        logic [3:0] alu;
        logic       rd;
        logic       as;
        logic       se;
        logic       m2r;
        logic       lh;
    } ev_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [3:0] alu;
        logic       rd, as, se, m2r, lh;
    } ins_t;

    ins_t tbl[$];
    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_cnt = 0;
    int   rmode = 2;

    function automatic void add(string nm, int o, int f, int k, int alu,
                                bit rd, bit as, bit se, bit m2r, bit lh);
        ins_t t;
        t.name = nm; t.op = 6'(o); t.fn = 6'(f); t.kind = k; t.alu = 4'(alu);
        t.rd = rd; t.as = as; t.se = se; t.m2r = m2r; t.lh = lh;
        tbl.push_back(t);
    endfunction

    function automatic int find(string nm);
        foreach (tbl[i]) if (tbl[i].name == nm) return i;
        return 0;
    endfunction

    function automatic int cpi(int k);
        case (k)
            K_J, K_JAL, K_SYS:        return 2;
            K_BEQ, K_BNE, K_BGEZ, K_JR: return 3;
            K_LD:                     return 5;
            default:                  return 4;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive an instruction and queue every strobe event it should produce
    task automatic issue(input int idx, input logic z, input logic s);
        ins_t t;
        ev_t  e;
        t = tbl[idx];
        op   = t.op;
        func = (t.op == 6'd0) ? t.fn : 6'($urandom_range(0, 63));
        zero = z;
        sign = s;
        e = '0; e.pw = 1'b1; e.irw = 1'b1; e.mr = 1'b1;
        exp_q.push_back(e);
        e = '0; e.alu = t.alu; e.rd = t.rd; e.as = t.as; e.se = t.se; e.m2r = t.m2r; e.lh = t.lh;
        case (t.kind)
            K_R, K_I: begin e.rw = 1'b1; exp_q.push_back(e); end
            K_LD: begin
                e.mr = 1'b1; e.io = 1'b1; exp_q.push_back(e);
                e.mr = 1'b0; e.io = 1'b0; e.rw = 1'b1; exp_q.push_back(e);
            end
            K_SW:   begin e.mw = 1'b1; e.io = 1'b1; exp_q.push_back(e); end
            K_BEQ:  if (z)  begin e.pw = 1'b1; e.ps = 2'd1; exp_q.push_back(e); end
            K_BNE:  if (!z) begin e.pw = 1'b1; e.ps = 2'd1; exp_q.push_back(e); end
            K_BGEZ: if (!s) begin e.pw = 1'b1; e.ps = 2'd1; exp_q.push_back(e); end
            K_JR:   begin e.pw = 1'b1; e.ps = 2'd3; exp_q.push_back(e); end
            K_J:    begin e = '0; e.pw = 1'b1; e.ps = 2'd2; exp_q.push_back(e); end
            K_JAL:  begin e = '0; e.pw = 1'b1; e.ps = 2'd2; e.rw = 1'b1; e.jl = 1'b1; exp_q.push_back(e); end
            default: ;
        endcase
        if (t.kind != K_ILL) model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic wait_retire(output int cyc);
        logic [CW-1:0] b;
        b = instr_count;
        cyc = 0;
        while (instr_count == b && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_instr(input int idx, input logic z, input logic s,
                             input int hold, input bit check_cpi);
        int cyc;
        issue(idx, z, s);
        wait_retire(cyc);
        chk({"count_", tbl[idx].name}, 32'(instr_count), 32'(model_cnt));
        if (check_cpi) chk({"cpi_", tbl[idx].name}, 32'(cyc), 32'(cpi(tbl[idx].kind)));
        if (tbl[idx].kind == K_SYS) begin
            for (int i = 0; i < hold; i++) begin
                chk("halt_hold", 32'({halted, mem_read, mem_write, iord, ir_write, pc_write, reg_write}),
                    32'h40);
                @(posedge clk); #1;
            end
            resume = 1'b1;
            @(posedge clk); #1;
            resume = 1'b0;
            chk("resume_to_fetch", 32'({halted, mem_read}), 32'h1);
        end
    endtask

    task automatic do_reset(input string nm);
        rmode = 2;
        mem_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk({nm, "_strobes"}, 32'({mem_read, mem_write, iord, ir_write, pc_write, reg_write, halted, illegal}),
            32'h80);
        chk({nm, "_count"}, 32'(instr_count), 32'h0);
        chk({nm, "_fields"}, 32'({alu_op, alu_src, signed_ext, reg_dst, mem_to_reg, lhu, jal}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // mem_ready source: always ready, random, or left to the directed sequences
    initial forever begin
        @(posedge clk); #1;
        if (rmode == 0)      mem_ready = 1'b1;
        else if (rmode == 1) mem_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: every pc/reg write or completed memory access is a scoreboard event
    initial begin : monitor
        ev_t a, e;
        forever begin
            @(negedge clk);
            if (!rst && (pc_write || reg_write || (mem_ready && (mem_read || mem_write)))) begin
                a = '0;
                a.pw = pc_write; a.ps = pc_src; a.irw = ir_write; a.rw = reg_write; a.jl = jal;
                a.mr = mem_read; a.mw = mem_write; a.io = iord; a.alu = alu_op; a.rd = reg_dst;
                a.as = alu_src; a.se = signed_ext; a.m2r = mem_to_reg; a.lh = lhu;
                if (a.irw || a.ps == 2'd2) begin
                    a.alu = '0; a.rd = 1'b0; a.as = 1'b0; a.se = 1'b0; a.m2r = 1'b0; a.lh = 1'b0;
                    if (a.irw) a.jl = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got 0x%0h, expected none", a);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", 32'(a), 32'(e));
                end
            end
        end
    end

    initial begin : main
        int cyc, n_legal, i_lw, i_sw, i_j;
        add("SLL", 0, 0, K_R, 0, 1, 0, 0, 0, 0);   add("SRL", 0, 2, K_R, 2, 1, 0, 0, 0, 0);
        add("SRA", 0, 3, K_R, 1, 1, 0, 0, 0, 0);   add("ADD", 0, 32, K_R, 5, 1, 0, 0, 0, 0);
        add("ADDU", 0, 33, K_R, 5, 1, 0, 0, 0, 0); add("SUB", 0, 34, K_R, 6, 1, 0, 0, 0, 0);
        add("AND", 0, 36, K_R, 7, 1, 0, 0, 0, 0);  add("OR", 0, 37, K_R, 8, 1, 0, 0, 0, 0);
        add("XOR", 0, 38, K_R, 9, 1, 0, 0, 0, 0);  add("NOR", 0, 39, K_R, 10, 1, 0, 0, 0, 0);
        add("SLT", 0, 42, K_R, 11, 1, 0, 0, 0, 0); add("SLTU", 0, 43, K_R, 12, 1, 0, 0, 0, 0);
        add("JR", 0, 8, K_JR, 5, 0, 0, 0, 0, 0);   add("SYSCALL", 0, 12, K_SYS, 0, 0, 0, 0, 0, 0);
        add("ADDI", 8, 0, K_I, 5, 0, 1, 1, 0, 0);  add("ADDIU", 9, 0, K_I, 5, 0, 1, 1, 0, 0);
        add("SLTI", 10, 0, K_I, 11, 0, 1, 1, 0, 0); add("ANDI", 12, 0, K_I, 7, 0, 1, 0, 0, 0);
        add("ORI", 13, 0, K_I, 8, 0, 1, 0, 0, 0);  add("XORI", 14, 0, K_I, 9, 0, 1, 0, 0, 0);
        add("LW", 35, 0, K_LD, 5, 0, 1, 1, 1, 0);  add("LHU", 37, 0, K_LD, 5, 0, 1, 1, 1, 1);
        add("SW", 43, 0, K_SW, 5, 0, 1, 1, 0, 0);  add("BEQ", 4, 0, K_BEQ, 6, 0, 0, 1, 0, 0);
        add("BNE", 5, 0, K_BNE, 6, 0, 0, 1, 0, 0); add("BGEZ", 1, 0, K_BGEZ, 11, 0, 0, 1, 0, 0);
        add("J", 2, 0, K_J, 0, 0, 0, 0, 0, 0);     add("JAL", 3, 0, K_JAL, 0, 0, 0, 0, 0, 0);
        n_legal = tbl.size();
        add("OP63", 63, 0, K_ILL, 0, 0, 0, 0, 0, 0);
        i_lw = find("LW"); i_sw = find("SW"); i_j = find("J");

        @(posedge clk); #1;
        do_reset("reset");

        // ALU instruction with memory always ready
        rmode = 0; mem_ready = 1'b1;
        run_instr(find("ADDU"), 1'b0, 1'b0, 0, 1'b1);

        // Load with three wait cycles in MEM
        rmode = 2; mem_ready = 1'b1;
        issue(i_lw, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("lw_mem_hold", 32'({mem_read, iord, mem_write}), 32'h6);
        end
        mem_ready = 1'b1;
        wait_retire(cyc);
        chk("lw_total_cycles", 32'(6 + cyc), 32'd8);
        chk("lw_count", 32'(instr_count), 32'(model_cnt));

        // Branches: BEQ taken and BNE not taken on zero=1
        rmode = 0; mem_ready = 1'b1;
        run_instr(find("BEQ"), 1'b1, 1'b0, 0, 1'b1);
        run_instr(find("BNE"), 1'b1, 1'b0, 0, 1'b1);

        // SYSCALL halt held ten cycles, then resume
        run_instr(find("SYSCALL"), 1'b0, 1'b0, 10, 1'b1);

        // Undefined opcode traps permanently until reset
        issue(find("OP63"), 1'b0, 1'b0);
        cyc = 0;
        while (!halted && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("trap_halted", 32'(halted), 32'h1);
        chk("trap_illegal", 32'(illegal), 32'h1);
        chk("trap_count", 32'(instr_count), 32'(model_cnt));
        resume = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("trap_resume_ignored", 32'({halted, illegal}), 32'h3);
        resume = 1'b0;
        do_reset("trap_reset");

        // Retire counter wraps at 2^CW
        rmode = 0; mem_ready = 1'b1;
        for (int i = 0; i < 15; i++) run_instr(i_j, 1'b0, 1'b0, 0, 1'b1);
        chk("wrap_15", 32'(instr_count), 32'd15);
        run_instr(i_j, 1'b0, 1'b0, 0, 1'b1);
        chk("wrap_0", 32'(instr_count), 32'd0);

        // Asynchronous reset while a store waits in MEM
        rmode = 2; mem_ready = 1'b1;
        issue(i_sw, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("sw_mem", 32'({mem_write, iord, mem_read}), 32'h6);
        #2;
        do_reset("sw_async_reset");

        // Random instruction mix with random memory latency
        rmode = 1;
        for (int n = 0; n < 200; n++)
            run_instr($urandom_range(0, n_legal - 1), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 2, 1'b0);

        rmode = 2; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle successor to the single-cycle decoder. It implements an FSM that sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with a variable-latency memory via mem_ready. Decoded control fields are held in registers for the duration of the instruction. The block also provides SYSCALL halt/resume, illegal-opcode trap and a retired-instruction counter. It sits between the IR/PC datapath and the shared instruction/data memory port.

Parameters:
ALU_OP_W, 4, width of alu_op; codes occupy the low 4 bits, upper bits zero.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
op  in  6  IR[31:26], valid from DECODE onward
func  in  6  IR[5:0]
zero  in  1  ALU result == 0 (EXEC cycle)
sign  in  1  ALU result bit 31 (EXEC cycle)
mem_ready  in  1  memory completes the current read/write this cycle
resume  in  1  leave SYSCALL halt
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  address source: 0=PC, 1=ALU result
ir_write  out  1  load IR from memory data
pc_write  out  1  update PC this cycle
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs (JR)
reg_write  out  1  register file write strobe
alu_op  out  ALU_OP_W  registered ALU function
alu_src, signed_ext, reg_dst, mem_to_reg, lhu, jal  out  1 each  registered decode fields, same meanings as the single-cycle controller
halted  out  1  in HALT state
illegal  out  1  sticky: undefined op/func decoded
instr_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async, immediate): state=FETCH; all decode registers, illegal and instr_count = 0.
- Reset values of outputs: mem_read=1 (FETCH), iord=0, all other strobes 0, halted=0.
- Strobes are combinational from state, decode registers, mem_ready, zero and sign. No strobe may be asserted outside the state listed below.
- FETCH:
  - mem_read=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise hold FETCH.
- DECODE: latch decode fields from op/func. ALU codes: SLL0, SRA1, SRL2, ADD/ADDU/ADDI/ADDIU/LW/LHU/SW/JR 5, SUB6, AND/ANDI 7, OR/ORI 8, XOR/XORI 9, NOR10, SLT/SLTI/BGEZ 11, SLTU12.
  - SYSCALL: next state HALT, count+1.
  - Undefined op/func: illegal<=1, next state HALT, no count.
  - J: pc_write=1, pc_src=2, count+1, next state FETCH.
  - JAL: as J, plus reg_write=1 and jal=1 (writes $31).
  - All other instructions: next state EXEC.
- EXEC:
  - BEQ: pc_write=zero. BNE: pc_write=!zero. BGEZ: pc_write=!sign. All three use pc_src=1, count+1, next state FETCH.
  - JR: pc_write=1, pc_src=3, count+1, next state FETCH.
  - LW/LHU/SW: next state MEM.
  - R-type and I-type ALU instructions: next state WB.
- MEM:
  - iord=1; mem_read=1 for loads, mem_write=1 for SW.
  - Hold until mem_ready.
  - On mem_ready: SW retires (count+1) and goes to FETCH; loads go to WB.
- WB: reg_write=1 for exactly one cycle, count+1, next state FETCH.
- HALT:
  - halted=1, all strobes 0.
  - If illegal=0 and resume=1: next state FETCH.
  - If illegal=1: remain in HALT until rst; resume is ignored.
- mem_ready outside FETCH/MEM is ignored.
- mem_ready high continuously: FETCH lasts one cycle. CPI: J/JAL/SYSCALL 2, branch/JR 3, ALU 4, SW 4, LW/LHU 5.
- Reset asserted mid-MEM: mem_write drops asynchronously and instr_count clears; the in-flight instruction is abandoned.
- instr_count at all-ones wraps to 0 on the next retirement.

Test Plan:
- Reset then mem_ready=1, IR ADDU (op0, func33): DECODE→EXEC→WB. WB cycle shows reg_write=1, alu_op=5, reg_dst=1; instr_count=1 after 4 cycles.
- LW (op35) with mem_ready low 3 cycles in MEM: mem_read and iord held for 4 cycles. WB follows with mem_to_reg=1; count+1; total 8 cycles.
- BEQ (op4) with zero=1, then BNE (op5) with zero=1: BEQ gives pc_write=1, pc_src=1 in EXEC; BNE gives pc_write=0. Both retire (count+2).
- SYSCALL (op0, func12): halted=1, strobes 0 for 10 cycles. resume=1 → FETCH next cycle.
- Undefined op 63: illegal=1, halted=1, resume ignored, count unchanged. rst clears illegal and returns to FETCH.
- CNT_W=4, 16 J instructions: count wraps 15→0. Async rst during MEM of SW: mem_write=0 immediately, state=FETCH.
